// File: rtl/can_bit_timing_pkg.sv
// Shared types and default widths for the CAN bit timing slice.
package can_pkg;

   typedef enum logic [1:0] {SEG_SYNC, SEG_SEG1, SEG_SEG2} bit_seg_t;

   localparam logic RECESSIVE = 1'b1;
   localparam logic DOMINANT  = 1'b0;

   localparam int BRP_W   = 8;
   localparam int TSEG1_W = 4;
   localparam int TSEG2_W = 3;
   localparam int SJW_W   = 2;

endpackage

// File: rtl/can_bit_timing_tq_prescaler.sv
// Time-quantum prescaler: tq_tick on the last clk of each tq; sync_clr makes
// the current clk count as the first clk of a fresh tq.
module can_tq_prescaler #(
   parameter int BRP_W = can_pkg::BRP_W
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             sync_clr,
   input  logic [BRP_W-1:0] brp,
   output logic             tq_tick
);

   logic [BRP_W-1:0] cnt;
   logic [BRP_W-1:0] cnt_eff;

   assign cnt_eff = sync_clr ? '0 : cnt;
   assign tq_tick = (cnt_eff == brp);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
      end else begin
         cnt <= tq_tick ? '0 : cnt_eff + BRP_W'(1);
      end
   end

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit timing: sequences SYNC/SEG1/SEG2 per bit, applies hard sync and
// SJW-limited resync, and emits the sample and transmit points.
module can_bit_timing #(
   parameter int BRP_W   = can_pkg::BRP_W,
   parameter int TSEG1_W = can_pkg::TSEG1_W,
   parameter int TSEG2_W = can_pkg::TSEG2_W,
   parameter int SJW_W   = can_pkg::SJW_W
) (
   input  logic               clk,
   input  logic               nRST,
   input  logic               edgedet,
   input  logic               canrx,
   input  logic               hard_sync_en,
   input  logic [BRP_W-1:0]   brp,
   input  logic [TSEG1_W-1:0] tseg1,
   input  logic [TSEG2_W-1:0] tseg2,
   input  logic [SJW_W-1:0]   sjw,
   output logic               sample_pulse,
   output logic               rx_bit,
   output logic               tx_point
);
   import can_pkg::*;

   // Segment counter must hold tseg1 + 1 + (sjw + 1) without wrapping.
   localparam int CW = TSEG1_W + 1;
   localparam int SW = CW + TSEG2_W + SJW_W + 2;

   bit_seg_t           state, state_n;
   logic [CW-1:0]      seg_cnt, cnt_n;
   logic [SJW_W:0]     ext, ext_n, ext_eff, sjw1;
   logic [TSEG2_W-1:0] adj, adj_n, seg2_end, end_eff;
   logic               adj_vld, adj_vld_n;
   logic               resync_done, done_n;
   logic               sample_n, tx_n, rx_n;
   logic               tq_tick, hard_sync, resync;

   function automatic logic [SJW_W:0] seg1_ext(input logic [CW-1:0] k,
                                                input logic [SJW_W:0] lim);
      logic [CW-1:0] k1;
      k1 = k + CW'(1);
      return (k1 < CW'(lim)) ? k1[SJW_W:0] : lim;
   endfunction

   // Shortened SEG2 end index; never earlier than the tq the edge landed in.
   function automatic logic [TSEG2_W-1:0] seg2_sat(input logic [CW-1:0] k,
                                                   input logic [TSEG2_W-1:0] t2,
                                                   input logic [SJW_W:0] lim);
      logic signed [SW-1:0] diff;
      logic signed [SW-1:0] ks;
      diff = $signed(SW'(t2)) - $signed(SW'(lim));
      ks   = $signed(SW'(k));
      return (diff > ks) ? TSEG2_W'(diff) : TSEG2_W'(k);
   endfunction

   assign sjw1      = {1'b0, sjw} + (SJW_W+1)'(1);
   assign seg2_end  = adj_vld ? adj : tseg2;
   assign hard_sync = hard_sync_en & edgedet;
   assign resync    = edgedet & ~hard_sync_en & (rx_bit == RECESSIVE) & ~resync_done;

   can_tq_prescaler #(.BRP_W(BRP_W)) u_prescaler (
      .clk      (clk),
      .nRST     (nRST),
      .sync_clr (hard_sync),
      .brp      (brp),
      .tq_tick  (tq_tick)
   );

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state        <= SEG_SYNC;
         seg_cnt      <= '0;
         ext          <= '0;
         adj          <= '0;
         adj_vld      <= 1'b0;
         resync_done  <= 1'b0;
         sample_pulse <= 1'b0;
         tx_point     <= 1'b0;
         rx_bit       <= RECESSIVE;
      end else begin
         state        <= state_n;
         seg_cnt      <= cnt_n;
         ext          <= ext_n;
         adj          <= adj_n;
         adj_vld      <= adj_vld_n;
         resync_done  <= done_n;
         sample_pulse <= sample_n;
         tx_point     <= tx_n;
         rx_bit       <= rx_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = seg_cnt;
      done_n    = resync_done;
      rx_n      = rx_bit;
      sample_n  = 1'b0;
      tx_n      = 1'b0;
      ext_eff   = ext;
      end_eff   = seg2_end;
      adj_vld_n = adj_vld;
      // Resync acts on the pre-tick segment and index; its result applies to this tq's end check.
      if (resync) begin
         done_n = 1'b1;
         case (state)
            SEG_SEG1: ext_eff = seg1_ext(seg_cnt, sjw1);
            SEG_SEG2: begin
               end_eff   = seg2_sat(seg_cnt, tseg2, sjw1);
               adj_vld_n = 1'b1;
            end
            default: ;
         endcase
      end
      ext_n = ext_eff;
      adj_n = end_eff;
      if (hard_sync) begin
         state_n   = tq_tick ? SEG_SEG1 : SEG_SYNC;
         cnt_n     = '0;
         ext_n     = '0;
         done_n    = 1'b0;
         adj_vld_n = 1'b0;
      end else if (tq_tick) begin
         case (state)
            SEG_SYNC: begin
               state_n = SEG_SEG1;
               cnt_n   = '0;
            end
            SEG_SEG1: begin
               if (seg_cnt == CW'(tseg1) + CW'(ext_eff)) begin
                  state_n  = SEG_SEG2;
                  cnt_n    = '0;
                  sample_n = 1'b1;
                  rx_n     = canrx;
               end else begin
                  cnt_n = seg_cnt + CW'(1);
               end
            end
            SEG_SEG2: begin
               if (seg_cnt == CW'(end_eff)) begin
                  state_n   = SEG_SYNC;
                  cnt_n     = '0;
                  tx_n      = 1'b1;
                  ext_n     = '0;
                  done_n    = 1'b0;
                  adj_vld_n = 1'b0;
               end else begin
                  cnt_n = seg_cnt + CW'(1);
               end
            end
            default: state_n = SEG_SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: directed timing scenarios plus randomized runs,
// checked against a tq-index model of the bit.
module tb_can_bit_timing;
   import can_pkg::*;

   logic               clk = 1'b0;
   logic               nRST = 1'b0;
   logic               edgedet = 1'b0;
   logic               canrx = 1'b1;
   logic               hard_sync_en = 1'b0;
   logic [BRP_W-1:0]   brp = '0;
   logic [TSEG1_W-1:0] tseg1 = '0;
   logic [TSEG2_W-1:0] tseg2 = '0;
   logic [SJW_W-1:0]   sjw = '0;
   logic               sample_pulse, rx_bit, tx_point;

   can_bit_timing dut (
      .clk          (clk),
      .nRST         (nRST),
      .edgedet      (edgedet),
      .canrx        (canrx),
      .hard_sync_en (hard_sync_en),
      .brp          (brp),
      .tseg1        (tseg1),
      .tseg2        (tseg2),
      .sjw          (sjw),
      .sample_pulse (sample_pulse),
      .rx_bit       (rx_bit),
      .tx_point     (tx_point)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int e0 = -1, e1 = -1, hs_until = 0, rx0_until = 0;
   int cb, ct1, ct2, cs;
   // Model: clk within tq, tq index within bit (0 = SYNC), current SEG1/SEG2 lengths in tq
   int mq, mt, ms1, ms2;
   bit mdone, mrx, msamp, mtx;
   int samp_q[$];
   int tx_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq = 0; mt = 0; ms1 = ct1 + 1; ms2 = ct2 + 1;
      mdone = 1'b0; mrx = 1'b1; msamp = 1'b0; mtx = 1'b0;
   endtask

   task automatic model_step(input bit e, input bit hs, input bit rx_in);
      int k;
      msamp = 1'b0;
      mtx   = 1'b0;
      if (hs && e) begin
         mq = 0; mt = 0; ms1 = ct1 + 1; ms2 = ct2 + 1; mdone = 1'b0;
      end else if (e && mrx && !mdone) begin
         mdone = 1'b1;
         if (mt >= 1 && mt <= ms1) begin
            ms1 = ms1 + ((mt < cs + 1) ? mt : cs + 1);
         end else if (mt > ms1) begin
            k   = mt - 1 - ms1;
            ms2 = ((k > ct2 - cs - 1) ? k : ct2 - cs - 1) + 1;
         end
      end
      if (mq == cb) begin
         mq = 0;
         mt++;
         if (mt == 1 + ms1) begin
            msamp = 1'b1;
            mrx   = rx_in;
         end else if (mt == 1 + ms1 + ms2) begin
            mtx = 1'b1; mt = 0; ms1 = ct1 + 1; ms2 = ct2 + 1; mdone = 1'b0;
         end
      end else begin
         mq++;
      end
   endtask

   task automatic cfg(input int b, input int t1, input int t2, input int s);
      cb = b; ct1 = t1; ct2 = t2; cs = s;
      brp   = BRP_W'(b);
      tseg1 = TSEG1_W'(t1);
      tseg2 = TSEG2_W'(t2);
      sjw   = SJW_W'(s);
   endtask

   task automatic do_reset();
      nRST = 1'b0; edgedet = 1'b0; hard_sync_en = 1'b0; canrx = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset sample_pulse", 32'(sample_pulse), 32'(0));
      chk("reset tx_point", 32'(tx_point), 32'(0));
      chk("reset rx_bit", 32'(rx_bit), 32'(1));
      model_reset();
      nRST = 1'b1;
      cyc = 0;
      samp_q.delete();
      tx_q.delete();
   endtask

   task automatic run(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         chk("sample_pulse", 32'(sample_pulse), 32'(msamp));
         chk("tx_point", 32'(tx_point), 32'(mtx));
         chk("rx_bit", 32'(rx_bit), 32'(mrx));
         if (sample_pulse) samp_q.push_back(cyc);
         if (tx_point) tx_q.push_back(cyc);
         hard_sync_en = (cyc < hs_until);
         if (rnd) begin
            edgedet = ($urandom_range(0, 5) == 0);
            canrx   = 1'($urandom_range(0, 1));
         end else begin
            edgedet = (cyc == e0) || (cyc == e1);
            canrx   = (cyc < rx0_until) ? 1'b0 : 1'b1;
         end
         model_step(edgedet, hard_sync_en, canrx);
         cyc++;
         @(negedge clk);
      end
      edgedet = 1'b0;
      hard_sync_en = 1'b0;
   endtask

   initial begin
      // Nominal timing
      cfg(0, 5, 2, 0); e0 = -1; e1 = -1; hs_until = 0; rx0_until = 0;
      do_reset();
      run(30, 1'b0);
      chk("nominal n_sample", 32'(samp_q.size()), 32'(3));
      chk("nominal sample0", 32'(samp_q[0]), 32'(7));
      chk("nominal sample1", 32'(samp_q[1]), 32'(17));
      chk("nominal sample2", 32'(samp_q[2]), 32'(27));
      chk("nominal n_tx", 32'(tx_q.size()), 32'(2));
      chk("nominal tx0", 32'(tx_q[0]), 32'(10));
      chk("nominal tx1", 32'(tx_q[1]), 32'(20));

      // Prescaler
      cfg(3, 5, 2, 0);
      do_reset();
      run(72, 1'b0);
      chk("presc sample0", 32'(samp_q[0]), 32'(28));
      chk("presc sample1", 32'(samp_q[1]), 32'(68));
      chk("presc tx0", 32'(tx_q[0]), 32'(40));

      // Hard sync at clk 4
      cfg(0, 5, 2, 0); e0 = 4; hs_until = 5;
      do_reset();
      run(16, 1'b0);
      chk("hsync sample0", 32'(samp_q[0]), 32'(11));
      chk("hsync tx0", 32'(tx_q[0]), 32'(14));
      hs_until = 0;

      // Late edge lengthens SEG1
      cfg(0, 5, 2, 1); e0 = 4;
      do_reset();
      run(14, 1'b0);
      chk("late sample0", 32'(samp_q[0]), 32'(9));
      chk("late tx0", 32'(tx_q[0]), 32'(12));

      // Early edge shortens SEG2
      cfg(0, 5, 2, 0); e0 = 7;
      do_reset();
      run(18, 1'b0);
      chk("early tx0", 32'(tx_q[0]), 32'(9));
      chk("early sample1", 32'(samp_q[1]), 32'(16));

      // Second edge in the same bit ignored
      cfg(0, 5, 2, 1); e0 = 4; e1 = 6;
      do_reset();
      run(14, 1'b0);
      chk("second sample0", 32'(samp_q[0]), 32'(9));
      chk("second tx0", 32'(tx_q[0]), 32'(12));

      // Edge while rx_bit is dominant: no adjustment
      cfg(0, 5, 2, 1); e0 = 14; e1 = -1; rx0_until = 10;
      do_reset();
      run(22, 1'b0);
      chk("dom sample1", 32'(samp_q[1]), 32'(17));
      chk("dom tx1", 32'(tx_q[1]), 32'(20));

      // Reset asserted in SEG2 while sample_pulse is high
      cfg(0, 5, 2, 0); e0 = -1; rx0_until = 7;
      do_reset();
      run(7, 1'b0);
      chk("pre-rst sample_pulse", 32'(sample_pulse), 32'(1));
      chk("pre-rst rx_bit", 32'(rx_bit), 32'(0));
      #2 nRST = 1'b0;
      #1;
      chk("midrst sample_pulse", 32'(sample_pulse), 32'(0));
      chk("midrst tx_point", 32'(tx_point), 32'(0));
      chk("midrst rx_bit", 32'(rx_bit), 32'(1));
      rx0_until = 0;
      model_reset();
      @(negedge clk);
      nRST = 1'b1;
      cyc = 0;
      samp_q.delete();
      tx_q.delete();
      run(10, 1'b0);
      chk("postrst sample0", 32'(samp_q[0]), 32'(7));

      // Randomized configurations and edge traffic
      for (int t = 0; t < 8; t++) begin
         cfg($urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3));
         hs_until = $urandom_range(0, 20);
         do_reset();
         run(150, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
